// File: rtl/uart_recv.sv
// UART receiver: oversamples rx, checks start/stop (and optional even parity), emits one-cycle pulses.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after the data bits.
module uart_recv #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_LENGTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   flag,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_LENGTH);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_LENGTH-1:0] shreg;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_d;
    logic                   parity_ok_c;

`ifdef UART_PARITY_EN
    logic parity_bit;
    assign parity_ok_c = ~(^{shreg, parity_bit});
`else
    assign parity_ok_c = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data       <= '0;
            flag       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rx_d       <= rx_s;
            flag       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            cnt        <= cnt + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // Falling edge only: a line held low never starts a frame
                    if (rx_d && !rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt            <= '0;
                        shreg[bit_cnt] <= rx_s;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        parity_bit <= rx_s;
                        state      <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid stop bit so a following start edge is not missed
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (parity_ok_c) begin
                            data <= shreg;
                            flag <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    shreg   <= '0;
                    data    <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: stimulus pushes expected pulses, a negedge monitor pops and checks.
module tb_uart_recv;

    localparam int unsigned C  = 16;
    localparam int unsigned DL = 8;
    localparam logic [2:0] K_FLAG = 3'b100;
    localparam logic [2:0] K_FERR = 3'b010;
    localparam logic [2:0] K_PERR = 3'b001;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DL-1:0] data;
    logic          flag;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    typedef struct {
        logic [2:0]    kind;
        logic [DL-1:0] word;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DL-1:0] last_good = '0;

    uart_recv #(.CLKS_PER_BIT(C), .DATA_LENGTH(DL)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .flag(flag),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_good = '0;
        end else if (flag || frame_err || parity_err) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got %b%b%b expected none at %0t",
                         flag, frame_err, parity_err, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {29'd0, flag, frame_err, parity_err}, {29'd0, e.kind});
                if (e.kind == K_FLAG) last_good = e.word;
                check("pulse_data", {24'd0, data}, {24'd0, last_good});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        tick(n);
    endtask

    // Reference outcome of a frame from its line-level contents
    function automatic logic [2:0] outcome(input logic [DL-1:0] w, input logic par, input logic stop);
        bit par_en;
`ifdef UART_PARITY_EN
        par_en = 1'b1;
`else
        par_en = 1'b0;
`endif
        if (!stop) return K_FERR;
        if (par_en && ((^w) ^ par)) return K_PERR;
        return K_FLAG;
    endfunction

    task automatic send_frame(input logic [DL-1:0] w, input logic par, input logic stop);
        exp_t e;
        e.kind = outcome(w, par, stop);
        e.word = w;
        exp_q.push_back(e);
        hold(1'b0, C);
        for (int i = 0; i < DL; i++) begin
            rx = w[i];
            tick(C / 2);
            check("busy_in_frame", {31'd0, busy}, 32'd1);
            tick(C - C / 2);
        end
`ifdef UART_PARITY_EN
        hold(par, C);
`endif
        hold(stop, C);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [DL-1:0] w;
        logic          stop;
        logic          par;

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check("reset_outputs", {20'd0, data, flag, frame_err, parity_err, busy}, 32'd0);
        rst = 1'b0;
        hold(1'b1, 2 * C);

        // Single good frame
        send_frame(8'hA5, ^8'hA5, 1'b1);
        hold(1'b1, C);
        drain();
        check("data_a5", {24'd0, data}, 32'hA5);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        hold(1'b1, C);
        drain();

        // Bad stop bit, long low line, then recovery
        send_frame(8'h55, ^8'h55, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 2 * C);
        drain();
        check("data_kept_after_ferr", {24'd0, data}, 32'h3C);
        send_frame(8'h12, ^8'h12, 1'b1);
        hold(1'b1, C);
        drain();

        // Short glitch must not start a frame
        hold(1'b0, 5);
        hold(1'b1, 7);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        hold(1'b1, C);

        // Reset mid bit 4
        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(1'b1, C);
        hold(1'b0, C / 2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_midframe", {20'd0, data, flag, frame_err, parity_err, busy}, 32'd0);
        end
        rst = 1'b0;
        hold(1'b1, 2 * C);
        send_frame(8'h81, ^8'h81, 1'b1);
        hold(1'b1, C);
        drain();
        check("data_81", {24'd0, data}, 32'h81);

`ifdef UART_PARITY_EN
        send_frame(8'h03, 1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        hold(1'b1, C);
        drain();
        check("data_kept_after_perr", {24'd0, data}, 32'h03);
`endif

        // Randomized frames: occasional bad stop / bad parity, random gaps
        for (int n = 0; n < 30; n++) begin
            w    = DL'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = (^w) ^ ($urandom_range(0, 5) == 0);
            send_frame(w, par, stop);
            if (!stop) begin
                hold(1'b0, $urandom_range(0, 20));
                hold(1'b1, C + $urandom_range(0, C));
            end else if ($urandom_range(0, 1) == 1) begin
                hold(1'b1, $urandom_range(1, 40));
            end
        end
        hold(1'b1, C);
        drain();
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
